// File: rtl/jru_pkg.sv
// Shared definitions for the jump redirect unit: jump opcodes, condition codes and FSM states.
package jru_pkg;

  localparam logic [4:0] OP_JMP = 5'b10100;
  localparam logic [4:0] OP_BCC = 5'b10111;

  // Condition codes in instr[10:8]; flags arrive as {s,z,c,v}.
  typedef enum logic [2:0] {
    C_EQ = 3'b000,  // z
    C_LT = 3'b001,  // s^v
    C_LE = 3'b010,  // z | (s^v)
    C_NE = 3'b011,  // !z
    C_CS = 3'b100,  // c
    C_CC = 3'b101,  // !c
    C_GE = 3'b110,  // !(s^v)
    C_GT = 3'b111   // !z & !(s^v)
  } cond_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDIR  = 2'd1,
    S_SQUASH = 2'd2
  } state_e;

endpackage

// File: rtl/jru_cond_eval.sv
// Combinational SZCV condition evaluator for conditional jumps.
module jru_cond_eval
  import jru_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] szcv,
  output logic       cond_true
);

  logic s, z, c, v, lt;

  assign s  = szcv[3];
  assign z  = szcv[2];
  assign c  = szcv[1];
  assign v  = szcv[0];
  assign lt = s ^ v;

  always_comb begin
    cond_true = 1'b0;
    unique case (cond_e'(cond))
      C_EQ: cond_true = z;
      C_LT: cond_true = lt;
      C_LE: cond_true = z | lt;
      C_NE: cond_true = ~z;
      C_CS: cond_true = c;
      C_CC: cond_true = ~c;
      C_GE: cond_true = ~lt;
      C_GT: cond_true = ~z & ~lt;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/jump_redirect_unit.sv
// Branch-resolution stage: decodes jumps, sends the target to fetch, squashes wrong-path slots.
// Optional taken/not-taken statistics counters are built when JRU_STATS_EN is defined.
module jump_redirect_unit
  import jru_pkg::*;
#(
  parameter int PC_W        = 12,
  parameter int OFF_W       = 8,
  parameter int FLUSH_SLOTS = 2,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     instr,
  input  logic [3:0]      szcv,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [PC_W-1:0] redir_pc,
  output logic            squash,
  output state_e          dbg_state_o
`ifdef JRU_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_nt
`endif
);

  localparam int SQ_W = (FLUSH_SLOTS > 0) ? $clog2(FLUSH_SLOTS + 1) : 1;

  // Redirect handshake: fetch sees a request while redir_valid=1; it completes on the
  // edge where redir_valid=1 and redir_ready=1. redir_pc is held stable until then.

  state_e            state_q, state_d;
  logic [PC_W-1:0]   redir_pc_q, redir_pc_d;
  logic [SQ_W-1:0]   squash_cnt_q, squash_cnt_d;

  logic [OFF_W-1:0]  off;
  logic [PC_W-1:0]   target;
  logic              is_jmp, is_bcc, cond_true;
  logic              eval_en, taken, bcc_not_taken;

  assign off    = instr[OFF_W-1:0];
  assign target = pc + {{(PC_W-OFF_W){off[OFF_W-1]}}, off} + PC_W'(1);
  assign is_jmp = (instr[15:11] == OP_JMP);
  assign is_bcc = (instr[15:11] == OP_BCC);

  jru_cond_eval u_cond (
    .cond      (instr[10:8]),
    .szcv      (szcv),
    .cond_true (cond_true)
  );

  // Only instructions accepted in S_IDLE are evaluated; squashed or flushed ones never are.
  assign eval_en       = in_valid & (state_q == S_IDLE) & ~flush;
  assign taken         = eval_en & (is_jmp | (is_bcc & cond_true));
  assign bcc_not_taken = eval_en & is_bcc & ~cond_true;

  always_comb begin
    state_d      = state_q;
    redir_pc_d   = redir_pc_q;
    squash_cnt_d = squash_cnt_q;
    in_ready     = 1'b1;
    squash       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (taken) begin
          redir_pc_d = target;
          state_d    = S_REDIR;
        end
      end
      S_REDIR: begin
        in_ready = 1'b0;
        if (redir_ready) begin
          if (FLUSH_SLOTS == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d      = S_SQUASH;
            squash_cnt_d = SQ_W'(FLUSH_SLOTS);
          end
        end
      end
      S_SQUASH: begin
        squash = 1'b1;
        if (in_valid) begin
          squash_cnt_d = squash_cnt_q - SQ_W'(1);
          if (squash_cnt_q == SQ_W'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // External flush overrides a pending redirect, a handshake and any squash in progress.
    if (flush) begin
      state_d      = S_IDLE;
      squash_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      redir_pc_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      redir_pc_q   <= redir_pc_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign redir_valid = (state_q == S_REDIR);
  assign redir_pc    = redir_pc_q;
  assign dbg_state_o = state_q;

`ifdef JRU_STATS_EN
  logic [CNT_W-1:0] stat_taken_q, stat_nt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_taken_q <= '0;
      stat_nt_q    <= '0;
    end else begin
      if (taken && (stat_taken_q != '1)) stat_taken_q <= stat_taken_q + CNT_W'(1);
      if (bcc_not_taken && (stat_nt_q != '1)) stat_nt_q <= stat_nt_q + CNT_W'(1);
    end
  end

  assign stat_taken = stat_taken_q;
  assign stat_nt    = stat_nt_q;
`endif

endmodule

// File: tb/tb_jump_redirect_unit.sv
// Directed bench for jump_redirect_unit (default FLUSH_SLOTS=2, PC_W=12, OFF_W=8).
module tb_jump_redirect_unit;
  import jru_pkg::*;

`ifdef JRU_STATS_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] pc;
  logic [15:0] instr;
  logic [3:0]  szcv;
  logic        redir_valid;
  logic        redir_ready;
  logic [11:0] redir_pc;
  logic        squash;
  state_e      dbg_state;
`ifdef JRU_STATS_EN
  logic [TB_CNT_W-1:0] stat_taken, stat_nt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jump_redirect_unit #(
    .PC_W(12), .OFF_W(8), .FLUSH_SLOTS(2), .CNT_W(TB_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .instr(instr), .szcv(szcv), .redir_valid(redir_valid),
    .redir_ready(redir_ready), .redir_pc(redir_pc), .squash(squash),
    .dbg_state_o(dbg_state)
`ifdef JRU_STATS_EN
    , .stat_taken(stat_taken), .stat_nt(stat_nt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference condition table, written from the ISA description.
  function automatic logic cond_model(input logic [2:0] c, input logic [3:0] f);
    logic s, z, cy, v;
    s = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      3'd0: return z;
      3'd1: return s != v;
      3'd2: return z || (s != v);
      3'd3: return !z;
      3'd4: return cy;
      3'd5: return !cy;
      3'd6: return s == v;
      default: return !z && (s == v);
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; pc = '0; instr = '0;
    szcv = '0; redir_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // Two valid filler slots consumed while squashing, then back in S_IDLE.
  task automatic drain_squash(input string tag);
    in_valid = 1'b1; instr = 16'h0000;
    step();
    check({tag, "_sq1"}, squash, 1);
    step();
    check({tag, "_sq_done"}, squash, 0);
    check({tag, "_idle"}, dbg_state, S_IDLE);
    in_valid = 1'b0;
  endtask

  task automatic run_jump(input string tag, input logic [11:0] p, input logic [15:0] ins,
                          input logic [3:0] f, input logic exp_taken, input logic [11:0] exp_pc);
    redir_ready = 1'b1;
    in_valid = 1'b1; pc = p; instr = ins; szcv = f;
    step();
    in_valid = 1'b0;
    check({tag, "_rv"}, redir_valid, exp_taken);
    if (exp_taken) begin
      check({tag, "_rpc"}, redir_pc, exp_pc);
      check({tag, "_ready_lo"}, in_ready, 0);
      step();
      check({tag, "_rv_drop"}, redir_valid, 0);
      check({tag, "_sq0"}, squash, 1);
      drain_squash(tag);
    end
  endtask

  initial begin
    logic [11:0] held_pc;
    logic [11:0] p;
    do_reset();
    check("rst_rv", redir_valid, 0);
    check("rst_rpc", redir_pc, 0);
    check("rst_ready", in_ready, 1);
    check("rst_squash", squash, 0);
    check("rst_state", dbg_state, S_IDLE);

    // 1. Unconditional jump: 0x010 + 5 + 1.
    run_jump("jmp", 12'h010, 16'hA005, 4'h0, 1'b1, 12'h016);

    // 2. Conditional on z, offset -2.
    run_jump("bcc_z1", 12'h100, 16'hB8FE, 4'b0100, 1'b1, 12'h0FF);
    run_jump("bcc_z0", 12'h100, 16'hB8FE, 4'b0000, 1'b0, 12'h000);
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 16; f++) begin
        p = 12'h200 + 12'(c * 16 + f);
        run_jump($sformatf("sweep_c%0d_f%0h", c, f), p, {5'b10111, 3'(c), 8'h03},
                 4'(f), cond_model(3'(c), 4'(f)), p + 12'd4);
      end
    end
    run_jump("not_jump", 12'h050, 16'h1234, 4'hF, 1'b0, 12'h000);

    // 3. Backpressure on the redirect.
    redir_ready = 1'b0;
    in_valid = 1'b1; pc = 12'h300; instr = 16'hA010; szcv = 4'h0;
    step();
    in_valid = 1'b0;
    held_pc = 12'h311;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_rv_%0d", i), redir_valid, 1);
      check($sformatf("bp_rpc_%0d", i), redir_pc, held_pc);
      check($sformatf("bp_ready_%0d", i), in_ready, 0);
      check($sformatf("bp_sq_%0d", i), squash, 0);
      step();
    end
    redir_ready = 1'b1;
    step();
    check("bp_hs_rv", redir_valid, 0);
    check("bp_hs_sq", squash, 1);

    // 4. Squash with gaps; the jump in the first slot is discarded.
    in_valid = 1'b1; pc = 12'h400; instr = 16'hA005;
    step();
    check("gap_s1_sq", squash, 1);
    in_valid = 1'b0;
    step();
    check("gap_s2_sq", squash, 1);
    check("gap_s2_rv", redir_valid, 0);
    step();
    check("gap_s3_sq", squash, 1);
    in_valid = 1'b1; instr = 16'h0000;
    step();
    check("gap_end_sq", squash, 0);
    check("gap_end_rv", redir_valid, 0);
    check("gap_end_state", dbg_state, S_IDLE);
    in_valid = 1'b0;

    // 5. flush during S_REDIR with a simultaneous handshake.
    redir_ready = 1'b0;
    in_valid = 1'b1; pc = 12'h500; instr = 16'hA001;
    step();
    in_valid = 1'b0;
    check("fl_pre_rv", redir_valid, 1);
    flush = 1'b1; redir_ready = 1'b1;
    step();
    flush = 1'b0;
    check("fl_rv", redir_valid, 0);
    check("fl_sq", squash, 0);
    check("fl_state", dbg_state, S_IDLE);
    step();
    check("fl_sq_after", squash, 0);
    // flush with a taken jump in S_IDLE
    flush = 1'b1; in_valid = 1'b1; pc = 12'h600; instr = 16'hA001;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_jmp_rv", redir_valid, 0);
    check("fl_jmp_state", dbg_state, S_IDLE);

    // 6. Wrap-around and jump-to-self.
    run_jump("wrap", 12'hFFF, 16'hA000, 4'h0, 1'b1, 12'h000);
    run_jump("self", 12'h123, 16'hA0FF, 4'h0, 1'b1, 12'h123);

`ifdef JRU_STATS_EN
    do_reset();
    check("st_rst_t", stat_taken, 0);
    check("st_rst_nt", stat_nt, 0);
    run_jump("st_j1", 12'h010, 16'hA005, 4'h0, 1'b1, 12'h016);
    run_jump("st_j2", 12'h010, 16'hA005, 4'h0, 1'b1, 12'h016);
    check("st_taken2", stat_taken, 2);
    run_jump("st_nt", 12'h100, 16'hB8FE, 4'b0000, 1'b0, 12'h000);
    check("st_nt1", stat_nt, 1);
    for (int i = 0; i < 3; i++)
      run_jump($sformatf("st_j%0d", i + 3), 12'h010, 16'hA005, 4'h0, 1'b1, 12'h016);
    check("st_taken_sat", stat_taken, 3);
    check("st_nt_hold", stat_nt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
